// File: rtl/door_lock_controller.sv
// ---------------------------------------------------------------------------
// door_lock_controller
//
// Top-level sequencer for the keypad door lock. Collects NUM_DIGITS decimal
// digits from keypad confirm presses and compares them with the stored
// password. It opens the door on a match and counts consecutive failures,
// entering a timed lockout after MAX_TRIES of them. An open door relocks
// after UNLOCK_CYCLES, and the password can be changed while the door is open.
//
// Optional feature macro: DOOR_LOCK_CLEAR_KEY_EN
//   When defined, pressing 4'hC in ENTRY or NEWPW clears the partial entry.
//   When undefined, 4'hC is ignored like every other non-decimal code.
//
// Ports:
//   i_clk            single clock, rising edge
//   i_reset          synchronous active-high reset
//   i_digit          keypad digit, sampled with a confirm press
//   i_confirm        keypad confirm level; a press is its 0->1 edge
//   i_lock           relock request level
//   i_change         password-change request (honoured in OPEN only)
//   o_unlocked       door open (registered)
//   o_alarm          lockout active (registered)
//   o_state          FSM state encoding
//   o_digit_count    digits currently held in the entry buffer
//   o_attempts_left  MAX_TRIES minus the consecutive failure count
// ---------------------------------------------------------------------------
module door_lock_controller #(
    parameter int                    NUM_DIGITS     = 3,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_PW   = 12'h123,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    LOCKOUT_CYCLES = 16,
    parameter int                    UNLOCK_CYCLES  = 32
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [3:0]                          i_digit,
    input  logic                                i_confirm,
    input  logic                                i_lock,
    input  logic                                i_change,
    output logic                                o_unlocked,
    output logic                                o_alarm,
    output logic [2:0]                          o_state,
    output logic [$clog2(NUM_DIGITS+1)-1:0]     o_digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]      o_attempts_left
);

    localparam int PW   = 4 * NUM_DIGITS;
    localparam int CW   = $clog2(NUM_DIGITS + 1);
    localparam int AW   = $clog2(MAX_TRIES + 1);
    localparam int TMAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TW   = $clog2(TMAX);

    localparam logic [CW-1:0] COUNT_FULL   = CW'(NUM_DIGITS);
    localparam logic [AW-1:0] TRIES_MAX    = AW'(MAX_TRIES);
    localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4,
        NEWPW   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   storedPw_q, storedPw_d;
    logic [PW-1:0]   digitBuf_q, digitBuf_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   fail_q, fail_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            confirm_q;
    logic            unlocked_q;
    logic            alarm_q;

    logic            press;
    logic            digitValid;
    logic            clearKey;
    logic [PW-1:0]   shifted;
    logic [CW-1:0]   countInc;
    logic [TW-1:0]   timerInc;

    assign press      = i_confirm && !confirm_q;
    assign digitValid = press && (i_digit <= 4'd9);
`ifdef DOOR_LOCK_CLEAR_KEY_EN
    assign clearKey   = press && (i_digit == 4'hC);
`else
    assign clearKey   = 1'b0;
`endif

    // First digit entered ends up in the most significant nibble.
    assign shifted  = {digitBuf_q[PW-5:0], i_digit};
    assign countInc = (count_q == COUNT_FULL) ? count_q : count_q + CW'(1);
    assign timerInc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

    // Next-state and datapath update; each state owns its counter bookkeeping.
    always_comb begin
        state_d    = state_q;
        storedPw_d = storedPw_q;
        digitBuf_d = digitBuf_q;
        count_d    = count_q;
        fail_d     = fail_q;
        timer_d    = timer_q;

        case (state_q)
            IDLE, ENTRY: begin
                if (clearKey && state_q == ENTRY) begin
                    digitBuf_d = '0;
                    count_d    = '0;
                    state_d    = IDLE;
                end else if (digitValid) begin
                    digitBuf_d = shifted;
                    count_d    = countInc;
                    state_d    = (countInc == COUNT_FULL) ? CHECK : ENTRY;
                end
            end

            CHECK: begin
                digitBuf_d = '0;
                count_d    = '0;
                timer_d    = '0;
                if (digitBuf_q == storedPw_q) begin
                    state_d = OPEN;
                    fail_d  = '0;
                end else if (fail_q + AW'(1) == TRIES_MAX) begin
                    state_d = LOCKOUT;
                    fail_d  = TRIES_MAX;
                end else begin
                    state_d = IDLE;
                    fail_d  = fail_q + AW'(1);
                end
            end

            OPEN: begin
                // Relock wins over both expiry and a change request.
                if (i_lock || timer_q == UNLOCK_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (i_change) begin
                    state_d    = NEWPW;
                    digitBuf_d = '0;
                    count_d    = '0;
                    timer_d    = '0;
                end else begin
                    timer_d = timerInc;
                end
            end

            NEWPW: begin
                // A press coincident with i_lock is dropped with the abort.
                if (i_lock) begin
                    state_d    = IDLE;
                    digitBuf_d = '0;
                    count_d    = '0;
                end else if (clearKey) begin
                    digitBuf_d = '0;
                    count_d    = '0;
                end else if (digitValid) begin
                    if (countInc == COUNT_FULL) begin
                        storedPw_d = shifted;
                        digitBuf_d = '0;
                        count_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        digitBuf_d = shifted;
                        count_d    = countInc;
                    end
                end
            end

            LOCKOUT: begin
                if (timer_q == LOCKOUT_LAST) begin
                    state_d = IDLE;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timerInc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; door and alarm outputs are registered from the
    // current state, so they follow a state change by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            storedPw_q <= DEFAULT_PW;
            digitBuf_q <= '0;
            count_q    <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            confirm_q  <= 1'b0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            storedPw_q <= storedPw_d;
            digitBuf_q <= digitBuf_d;
            count_q    <= count_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            confirm_q  <= i_confirm;
            unlocked_q <= (state_q == OPEN) || (state_q == NEWPW);
            alarm_q    <= (state_q == LOCKOUT);
        end
    end

    assign o_unlocked      = unlocked_q;
    assign o_alarm         = alarm_q;
    assign o_state         = state_q;
    assign o_digit_count   = count_q;
    assign o_attempts_left = TRIES_MAX - fail_q;

endmodule

// File: tb/tb_door_lock_controller.sv
// Testbench for door_lock_controller. Expected results are queued as the
// stimulus is driven and popped against the DUT outputs once they settle.
module tb_door_lock_controller;

   localparam int S_IDLE    = 0;
   localparam int S_ENTRY   = 1;
   localparam int S_CHECK   = 2;
   localparam int S_OPEN    = 3;
   localparam int S_LOCKOUT = 4;
   localparam int S_NEWPW   = 5;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] digit;
   logic       confirm;
   logic       lock;
   logic       change;
   logic       unlocked;
   logic       alarm;
   logic [2:0] state;
   logic [1:0] digitCount;
   logic [1:0] attemptsLeft;

   int totalCount = 0;
   int badCount   = 0;
   int unlockHigh = 0;
   int alarmHigh  = 0;

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t sbQueue[$];

   door_lock_controller dut (
      .i_clk           (clock),
      .i_reset         (reset),
      .i_digit         (digit),
      .i_confirm       (confirm),
      .i_lock          (lock),
      .i_change        (change),
      .o_unlocked      (unlocked),
      .o_alarm         (alarm),
      .o_state         (state),
      .o_digit_count   (digitCount),
      .o_attempts_left (attemptsLeft)
   );

   // 10-unit clock; all stimulus and sampling happens on the falling edge.
   always #5 clock = ~clock;

   // Running totals of cycles spent with the door open and the alarm on.
   always @(negedge clock) begin
      unlockHigh += int'(unlocked);
      alarmHigh  += int'(alarm);
   end

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input int got, input int want);
      totalCount++;
      if (got !== want) begin
         badCount++;
         $display("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic pushExp(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sbQueue.push_back(e);
   endtask

   task automatic popCheck(input int got);
      exp_t e;
      if (sbQueue.size() == 0) begin
         checkOutput("sb_underflow", sbQueue.size(), 1);
      end else begin
         e = sbQueue.pop_front();
         checkOutput(e.tag, got, e.val);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic doReset();
      reset   = 1'b1;
      digit   = 4'd0;
      confirm = 1'b0;
      lock    = 1'b0;
      change  = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   // One keypad press with confirm held for 'hold' cycles, then released.
   task automatic applyStimulus(input logic [3:0] d, input int hold);
      digit   = d;
      confirm = 1'b1;
      tick(hold);
      confirm = 1'b0;
      tick(1);
   endtask

   // Three presses; the state expected one cycle after the last acceptance
   // edge is queued first and checked once the presses are done.
   task automatic enterCode(input string tag, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] c,
                            input int wantState);
      pushExp(tag, wantState);
      applyStimulus(a, 1);
      applyStimulus(b, 1);
      applyStimulus(c, 1);
      popCheck(int'(state));
   endtask

   task automatic waitState(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (int'(state) != target && n < budget) begin
         tick(1);
         n++;
      end
      pushExp(tag, target);
      popCheck(int'(state));
   endtask

   task automatic relock();
      lock = 1'b1;
      tick(1);
      lock = 1'b0;
      tick(2);
   endtask

   initial begin
      int openStart;
      int alarmStart;

      reset   = 1'b1;
      digit   = 4'd0;
      confirm = 1'b0;
      lock    = 1'b0;
      change  = 1'b0;

      // ---- 1: reset state, correct code, latency, auto-relock ----
      doReset();
      pushExp("rst_state", S_IDLE);      popCheck(int'(state));
      pushExp("rst_unlocked", 0);        popCheck(int'(unlocked));
      pushExp("rst_alarm", 0);           popCheck(int'(alarm));
      pushExp("rst_count", 0);           popCheck(int'(digitCount));
      pushExp("rst_attempts", 3);        popCheck(int'(attemptsLeft));

      openStart = unlockHigh;
      applyStimulus(4'd1, 1);
      applyStimulus(4'd2, 1);
      pushExp("t1_count2", 2);           popCheck(int'(digitCount));
      digit   = 4'd3;
      confirm = 1'b1;
      pushExp("t1_check", S_CHECK);
      tick(1);
      popCheck(int'(state));
      confirm = 1'b0;
      pushExp("t1_open_state", S_OPEN);
      pushExp("t1_unlock_edge1", 0);
      tick(1);
      popCheck(int'(state));
      popCheck(int'(unlocked));
      pushExp("t1_unlock_edge2", 1);
      pushExp("t1_attempts", 3);
      tick(1);
      popCheck(int'(unlocked));
      popCheck(int'(attemptsLeft));
      waitState("t1_relock", S_IDLE, 60);
      tick(2);
      pushExp("t1_open_cycles", 32);     popCheck(unlockHigh - openStart);
      pushExp("t1_locked", 0);           popCheck(int'(unlocked));

      // ---- 2: three failures, lockout, ignored presses ----
      alarmStart = alarmHigh;
      enterCode("t2_fail1", 4'd4, 4'd5, 4'd6, S_IDLE);
      pushExp("t2_att2", 2);             popCheck(int'(attemptsLeft));
      enterCode("t2_fail2", 4'd4, 4'd5, 4'd6, S_IDLE);
      pushExp("t2_att1", 1);             popCheck(int'(attemptsLeft));
      enterCode("t2_fail3", 4'd4, 4'd5, 4'd6, S_LOCKOUT);
      pushExp("t2_att0", 0);             popCheck(int'(attemptsLeft));
      lock = 1'b1;
      applyStimulus(4'd1, 1);
      lock = 1'b0;
      pushExp("t2_lock_ignored", S_LOCKOUT); popCheck(int'(state));
      applyStimulus(4'd2, 1);
      applyStimulus(4'd3, 1);
      pushExp("t2_alarm_on", 1);         popCheck(int'(alarm));
      waitState("t2_lockout_end", S_IDLE, 40);
      tick(3);
      pushExp("t2_alarm_cycles", 16);    popCheck(alarmHigh - alarmStart);
      pushExp("t2_att_restored", 3);     popCheck(int'(attemptsLeft));
      pushExp("t2_no_open", 0);          popCheck(int'(unlocked));
      pushExp("t2_count", 0);            popCheck(int'(digitCount));

      // ---- 3: password change to 987 ----
      enterCode("t3_open", 4'd1, 4'd2, 4'd3, S_OPEN);
      change = 1'b1;
      tick(1);
      change = 1'b0;
      pushExp("t3_newpw", S_NEWPW);      popCheck(int'(state));
      enterCode("t3_stored", 4'd9, 4'd8, 4'd7, S_IDLE);
      pushExp("t3_locked", 0);           popCheck(int'(unlocked));
      enterCode("t3_old_fails", 4'd1, 4'd2, 4'd3, S_IDLE);
      pushExp("t3_att2", 2);             popCheck(int'(attemptsLeft));
      enterCode("t3_new_opens", 4'd9, 4'd8, 4'd7, S_OPEN);
      relock();
      pushExp("t3_relock", S_IDLE);      popCheck(int'(state));

      // ---- 4: invalid codes and held presses ----
      doReset();
      applyStimulus(4'hA, 5);
      pushExp("t4_cnt_A", 0);            popCheck(int'(digitCount));
      applyStimulus(4'd1, 5);
      pushExp("t4_cnt_1", 1);            popCheck(int'(digitCount));
      applyStimulus(4'hF, 5);
      pushExp("t4_cnt_F", 1);            popCheck(int'(digitCount));
      applyStimulus(4'd2, 5);
      pushExp("t4_cnt_2", 2);            popCheck(int'(digitCount));
      applyStimulus(4'd3, 5);
      pushExp("t4_open", 1);             popCheck(int'(unlocked));
      relock();

      // ---- 5: reset mid-entry and in NEWPW restores the default ----
      applyStimulus(4'd1, 1);
      applyStimulus(4'd2, 1);
      doReset();
      pushExp("t5_cnt_cleared", 0);      popCheck(int'(digitCount));
      enterCode("t5_open", 4'd1, 4'd2, 4'd3, S_OPEN);
      change = 1'b1;
      tick(1);
      change = 1'b0;
      applyStimulus(4'd9, 1);
      applyStimulus(4'd8, 1);
      pushExp("t5_newpw_cnt", 2);        popCheck(int'(digitCount));
      doReset();
      pushExp("t5_rst_state", S_IDLE);   popCheck(int'(state));
      pushExp("t5_rst_cnt", 0);          popCheck(int'(digitCount));
      pushExp("t5_rst_unlock", 0);       popCheck(int'(unlocked));
      enterCode("t5_default_pw", 4'd1, 4'd2, 4'd3, S_OPEN);

      // ---- 6: lock and change together ----
      tick(2);
      lock   = 1'b1;
      change = 1'b1;
      tick(1);
      lock   = 1'b0;
      change = 1'b0;
      pushExp("t6_lock_wins", S_IDLE);   popCheck(int'(state));
      tick(1);
      pushExp("t6_still_idle", S_IDLE);  popCheck(int'(state));
      enterCode("t6_pw_kept", 4'd1, 4'd2, 4'd3, S_OPEN);
      relock();

      // ---- clear key behaviour (depends on build option) ----
      applyStimulus(4'd5, 1);
      applyStimulus(4'hC, 1);
`ifdef DOOR_LOCK_CLEAR_KEY_EN
      pushExp("ck_count", 0);
      pushExp("ck_state", S_IDLE);
`else
      pushExp("ck_count", 1);
      pushExp("ck_state", S_ENTRY);
`endif
      popCheck(int'(digitCount));
      popCheck(int'(state));

      checkOutput("sb_leftover", sbQueue.size(), 0);
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
